// File: rtl/marquee_msg_loader.sv
// Marquee message loader: takes ASCII bytes over valid/ready, encodes them to
// active-low 7-seg patterns and commits a full frame to the scroller.
module marquee_msg_loader #(
    parameter int         NCHAR = 8,
    parameter logic [6:0] BLANK = 7'h7F
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CH_VALID,
    output logic                 CH_READY,
    input  logic [7:0]           CH_DATA,
    input  logic                 CH_LAST,
    output logic [7*NCHAR-1:0]   WORDS,
    output logic                 WORDS_LOAD,
    output logic                 TRUNC
);

    localparam int W  = 7 * NCHAR;
    localparam int IW = $clog2(NCHAR + 1);

    typedef enum logic {
        S_FILL,
        S_COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    shadow_q, shadow_d;
    logic [W-1:0]    words_q, words_d;
    logic            load_q, load_d;
    logic            trunc_q, trunc_d;
    logic            pend_q, pend_d;
    logic            accept;
    logic [6:0]      seg;

    function automatic logic [6:0] enc(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            "0": enc = 7'h40;
            "1": enc = 7'h79;
            "2": enc = 7'h24;
            "3": enc = 7'h30;
            "4": enc = 7'h19;
            "5": enc = 7'h12;
            "6": enc = 7'h02;
            "7": enc = 7'h78;
            "8": enc = 7'h00;
            "9": enc = 7'h10;
            "A": enc = 7'h08;
            "B": enc = 7'h03;
            "C": enc = 7'h46;
            "D": enc = 7'h21;
            "E": enc = 7'h06;
            "F": enc = 7'h0E;
            "G": enc = 7'h42;
            "H": enc = 7'h09;
            "I": enc = 7'h79;
            "J": enc = 7'h61;
            "L": enc = 7'h47;
            "N": enc = 7'h2B;
            "O": enc = 7'h23;
            "P": enc = 7'h0C;
            "Q": enc = 7'h18;
            "R": enc = 7'h2F;
            "S": enc = 7'h12;
            "T": enc = 7'h07;
            "U": enc = 7'h41;
            "Y": enc = 7'h11;
            "Z": enc = 7'h24;
            "-": enc = 7'h3F;
            "_": enc = 7'h77;
            default: enc = BLANK;
        endcase
    endfunction

    assign seg        = enc(CH_DATA);
    assign CH_READY   = (state_q == S_FILL) && !RST;
    assign accept     = CH_VALID && CH_READY;
    assign WORDS      = words_q;
    assign WORDS_LOAD = load_q;
    assign TRUNC      = trunc_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        words_d  = words_q;
        load_d   = 1'b0;
        trunc_d  = trunc_q;
        pend_d   = pend_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    // Bytes past the last slot are dropped but remembered.
                    if (idx_q < IW'(NCHAR)) begin
                        for (int i = 0; i < NCHAR; i++) begin
                            if (idx_q == IW'(i)) begin
                                shadow_d[W-1-7*i -: 7] = seg;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                    if (CH_LAST) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                words_d  = shadow_q;
                load_d   = 1'b1;
                trunc_d  = pend_q;
                shadow_d = {NCHAR{BLANK}};
                idx_d    = '0;
                pend_d   = 1'b0;
                state_d  = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_FILL;
            idx_q    <= '0;
            shadow_q <= {NCHAR{BLANK}};
            words_q  <= {NCHAR{BLANK}};
            load_q   <= 1'b0;
            trunc_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            words_q  <= words_d;
            load_q   <= load_d;
            trunc_q  <= trunc_d;
            pend_q   <= pend_d;
        end
    end

endmodule
